memory_responder: RTL and testbench
===================================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning cycles from request sample to MEM_MFC assertion; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of the number of implemented 32-bit words.
REQ-003 SHALL have parameter INIT_FILE, default "program.mif", meaning the word-image preloaded into storage at configuration.
REQ-004 SHALL have port Clock, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port MEM_Address, input, 32 bits: word address from the processor.
REQ-007 SHALL have port MEM_Data_In, input, 32 bits: write data from the processor.
REQ-008 SHALL have port MEM_r_w_z_z, input, 2 bits: 00 read, 01 write, 1x idle/high-impedance (no request).
REQ-009 SHALL have port MEM_Data_Out, output, 32 bits: read data to the processor.
REQ-010 SHALL have port MEM_MFC, output, 1 bit: memory function complete.
REQ-011 SHALL have port MEM_ERROR, output, 1 bit: address not assigned.
REQ-012 SHALL have port Busy, output, 1 bit: access in progress (debug).

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, DONE, FAULT.
REQ-014 In IDLE, MEM_r_w_z_z of 00 or 01 SHALL be a request and SHALL be sampled together with MEM_Address on that edge.
REQ-015 A request with MEM_Address >= 2^DEPTH_LOG2 SHALL go IDLE->FAULT; storage SHALL NOT be touched.
REQ-016 A legal request SHALL go IDLE->WAIT with countdown LATENCY-1, or directly IDLE->DONE when LATENCY=1.
REQ-017 WAIT SHALL decrement each cycle and go WAIT->DONE when the count reaches 0, so that MEM_MFC rises exactly LATENCY cycles after the sampling edge.
REQ-018 A write SHALL commit MEM_Data_In to storage exactly once, on the edge entering DONE.
REQ-019 A read SHALL register the addressed word into MEM_Data_Out on the edge entering DONE.
REQ-020 In DONE, MEM_MFC SHALL be 1 and MEM_Data_Out SHALL be held for as long as address and command are unchanged.
REQ-021 In FAULT, MEM_MFC and MEM_ERROR SHALL both be 1, so the processor never hangs.
REQ-022 DONE or FAULT SHALL go to IDLE when the command becomes 1x, or when the address or command differs from the sampled values.
REQ-023 A changed request SHALL therefore be served after one IDLE bubble cycle.
REQ-024 If the request changes or is withdrawn while in WAIT, the access SHALL abort to IDLE, with no write and MEM_Data_Out unchanged.
REQ-025 MEM_Data_Out SHALL retain its last read value outside DONE; writes SHALL NOT alter it.
REQ-026 Busy SHALL be 1 only in WAIT; MEM_MFC and MEM_ERROR SHALL be 0 in IDLE and WAIT.
REQ-027 Address comparison SHALL use all 32 bits; storage indexing SHALL use MEM_Address[DEPTH_LOG2-1:0].

Reset
REQ-028 Reset_n low SHALL asynchronously force state IDLE, countdown 0, MEM_Data_Out 0, MEM_MFC 0, MEM_ERROR 0, Busy 0.
REQ-029 Reset SHALL NOT clear storage contents.
REQ-030 Reset asserted mid-WAIT SHALL discard the pending write.
REQ-031 A request held across reset release SHALL be sampled on the first rising edge after release.

Structure
REQ-032 The FSM state encoding and the MEM_r_w_z_z command constants (READ=00, WRITE=01, IDLE=1x) SHALL reside in shared package mem_bus_pkg, which the processor side also uses.
REQ-033 Storage SHALL be one sub-module, mem_word_array: synchronous single-port, 32-bit wide, 2^DEPTH_LOG2 deep, initialised from INIT_FILE.

Verification
REQ-034 With LATENCY=2: read 00 at address 0x5 holding 0xDEADBEEF, applied at edge 0 -> MEM_MFC=1 and MEM_Data_Out=0xDEADBEEF after edge 2, both held while the request is held.
REQ-035 Write 01 to address 0x10 with data 0x12345678, held 6 cycles -> storage written once; a subsequent read of 0x10 returns 0x12345678; MEM_Data_Out is unchanged during the write.
REQ-036 Read of address 0x100 with DEPTH_LOG2=8 -> MEM_MFC=1 and MEM_ERROR=1 after 1 edge; setting the command to 10 returns both to 0 on the next edge.
REQ-037 With LATENCY=3: write to 0x7 issued, then address changed to 0x8 after 1 cycle -> word 0x7 is unmodified and the read of 0x8 completes 1 bubble + 3 cycles later.
REQ-038 Reset_n pulsed low mid-WAIT of a write -> outputs go to 0 immediately and storage is unchanged; the held request is re-served after release.
REQ-039 Back-to-back reads of 0x1 then 0x2 (address switched on the MEM_MFC cycle) with LATENCY=1 -> MEM_MFC pattern 1,0,1 and data updates accordingly.

Source files
------------

// File: rtl/mem_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_bus_pkg : memory bus command codes and responder FSM states    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } mem_state_e;

  localparam logic [1:0] c_CMD_READ  = 2'b00;
  localparam logic [1:0] c_CMD_WRITE = 2'b01;
  localparam logic [1:0] c_CMD_IDLE  = 2'b10;

  // Any code with the upper bit set means the bus is idle / tri-stated.
  function automatic logic is_request(input logic [1:0] cmd);
    return ~cmd[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_word_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_word_array : synchronous single-port 32-bit word storage       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_word_array #(
  parameter int DEPTH_LOG2 = 8,
  parameter     INIT_FILE  = "program.mif"
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  // The word image is attached to the RAM as configuration content.
  (* ram_init_file = INIT_FILE *) logic [31:0] mem_q [2**DEPTH_LOG2];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read port register doubles as the bus data-out holding register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_q <= 32'd0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/memory_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | memory_responder : latency-modelled memory slave with MFC/ERROR    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module memory_responder
  import mem_bus_pkg::*;
#(
  parameter int LATENCY    = 2,
  parameter int DEPTH_LOG2 = 8,
  parameter     INIT_FILE  = "program.mif"
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [31:0] MEM_Address,
  input  logic [31:0] MEM_Data_In,
  input  logic [1:0]  MEM_r_w_z_z,
  output logic [31:0] MEM_Data_Out,
  output logic        MEM_MFC,
  output logic        MEM_ERROR,
  output logic        Busy
);

  mem_state_e  state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [1:0]  cmd_q;
  logic        mfc_q;
  logic        err_q;
  logic        busy_q;

  logic w_req;
  logic w_legal;
  logic w_same;
  logic w_enter_done;
  logic w_is_write;

  assign w_req      = is_request(MEM_r_w_z_z);
  assign w_legal    = (MEM_Address >> DEPTH_LOG2) == 32'd0;
  assign w_same     = w_req && (MEM_Address == addr_q) && (MEM_r_w_z_z == cmd_q);
  assign w_is_write = (MEM_r_w_z_z == c_CMD_WRITE);

  // Storage is touched only on the single edge that moves the FSM into DONE.
  always_comb begin
    w_enter_done = 1'b0;
    if (state_q == ST_IDLE) begin
      w_enter_done = w_req && w_legal && (LATENCY == 1);
    end else if (state_q == ST_WAIT) begin
      w_enter_done = w_same && (cnt_q == 4'd1);
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      cmd_q   <= c_CMD_IDLE;
      mfc_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_req) begin
            addr_q <= MEM_Address;
            cmd_q  <= MEM_r_w_z_z;
            if (!w_legal) begin
              state_q <= ST_FAULT;
              mfc_q   <= 1'b1;
              err_q   <= 1'b1;
            end else if (LATENCY == 1) begin
              state_q <= ST_DONE;
              mfc_q   <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= 4'(LATENCY - 1);
              busy_q  <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (!w_same) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
          end else if (cnt_q == 4'd1) begin
            state_q <= ST_DONE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            mfc_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_DONE, ST_FAULT: begin
          if (!w_same) begin
            state_q <= ST_IDLE;
            mfc_q   <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  mem_word_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .clk_i   (Clock),
    .rst_n_i (Reset_n),
    .en_i    (w_enter_done),
    .we_i    (w_is_write),
    .addr_i  (MEM_Address[DEPTH_LOG2-1:0]),
    .wdata_i (MEM_Data_In),
    .rdata_o (MEM_Data_Out)
  );

  assign MEM_MFC   = mfc_q;
  assign MEM_ERROR = err_q;
  assign Busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_memory_responder : three responders at LATENCY 1, 2 and 3       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_memory_responder;
  import mem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr_s [3];
  logic [31:0] din_s  [3];
  logic [1:0]  cmd_s  [3];
  logic [31:0] dout_w [3];
  logic        mfc_w  [3];
  logic        err_w  [3];
  logic        busy_w [3];

  logic [31:0] mdl      [3][32];
  logic [31:0] exp_dout [3];
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Instance g has LATENCY g+1.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    memory_responder #(
      .LATENCY    (g + 1),
      .DEPTH_LOG2 (8),
      .INIT_FILE  ("program.mif")
    ) u_dut (
      .Clock        (clk),
      .Reset_n      (rst_n),
      .MEM_Address  (addr_s[g]),
      .MEM_Data_In  (din_s[g]),
      .MEM_r_w_z_z  (cmd_s[g]),
      .MEM_Data_Out (dout_w[g]),
      .MEM_MFC      (mfc_w[g]),
      .MEM_ERROR    (err_w[g]),
      .Busy         (busy_w[g])
    );
  end

  function automatic logic [34:0] obs(input int d);
    return {mfc_w[d], err_w[d], busy_w[d], dout_w[d]};
  endfunction

  // One complete bus transaction, driven and checked from a negedge.
  task automatic access(input int d, input logic [1:0] cmd, input logic [31:0] a,
                        input logic [31:0] wd, input int hold, input string tag);
    int lat;
    bit bad;
    logic [34:0] exp;
    bad = (a > 32'd255);
    lat = bad ? 1 : d + 1;
    cmd_s[d] = cmd; addr_s[d] = a; din_s[d] = wd;
    for (int n = 1; n < lat; n++) begin
      @(negedge clk);
      nvec++;
      exp = {1'b0, 1'b0, 1'b1, exp_dout[d]};
      if (obs(d) !== exp) begin
        nerr++;
        $display("FAIL %s wait%0d: got %h expected %h", tag, n, obs(d), exp);
      end
    end
    @(negedge clk);
    if (!bad) begin
      if (cmd == c_CMD_WRITE) mdl[d][a[4:0]] = wd;
      else exp_dout[d] = mdl[d][a[4:0]];
    end
    for (int h = 0; h <= hold; h++) begin
      nvec++;
      exp = {1'b1, bad, 1'b0, exp_dout[d]};
      if (obs(d) !== exp) begin
        nerr++;
        $display("FAIL %s done%0d: got %h expected %h", tag, h, obs(d), exp);
      end
      if (h < hold) @(negedge clk);
    end
    cmd_s[d] = c_CMD_IDLE;
    @(negedge clk);
    nvec++;
    exp = {1'b0, 1'b0, 1'b0, exp_dout[d]};
    if (obs(d) !== exp) begin
      nerr++;
      $display("FAIL %s release: got %h expected %h", tag, obs(d), exp);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      cmd_s[d] = c_CMD_IDLE; addr_s[d] = 32'd0; din_s[d] = 32'd0; exp_dout[d] = 32'd0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      nvec++;
      if (obs(d) !== 35'd0) begin
        nerr++;
        $display("FAIL reset[%0d]: got %h expected 0", d, obs(d));
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int d = 0; d < 3; d++)
      for (int a = 0; a < 32; a++)
        access(d, c_CMD_WRITE, 32'(a), $urandom, 0, "fill");
  endtask

  task automatic test_read_latency();
    access(1, c_CMD_WRITE, 32'h5, 32'hDEADBEEF, 0, "wr5");
    access(1, c_CMD_READ, 32'h5, 32'h0, 3, "rd5");
    access(1, c_CMD_WRITE, 32'h10, 32'h12345678, 5, "wr10");
    access(1, c_CMD_READ, 32'h10, 32'h0, 1, "rd10");
  endtask

  task automatic test_fault();
    access(1, c_CMD_READ, 32'h100, 32'h0, 2, "fault100");
    access(2, c_CMD_WRITE, 32'h8000_0005, 32'hBAD0BAD0, 1, "fault_hi");
    access(2, c_CMD_READ, 32'h5, 32'h0, 0, "rd5_after_fault");
  endtask

  task automatic test_abort();
    logic [34:0] exp;
    cmd_s[2] = c_CMD_WRITE; addr_s[2] = 32'h7; din_s[2] = ~mdl[2][7];
    @(negedge clk);
    cmd_s[2] = c_CMD_READ; addr_s[2] = 32'h8;
    @(negedge clk);
    nvec++;
    exp = {3'b000, exp_dout[2]};
    if (obs(2) !== exp) begin
      nerr++;
      $display("FAIL abort_bubble: got %h expected %h", obs(2), exp);
    end
    access(2, c_CMD_READ, 32'h8, 32'h0, 0, "abort_rd8");
    access(2, c_CMD_READ, 32'h7, 32'h0, 0, "abort_rd7");
  endtask

  task automatic test_reset_midwait();
    logic [34:0] exp;
    cmd_s[2] = c_CMD_WRITE; addr_s[2] = 32'h1F; din_s[2] = ~mdl[2][31];
    @(negedge clk);
    nvec++;
    exp = {3'b001, exp_dout[2]};
    if (obs(2) !== exp) begin
      nerr++;
      $display("FAIL rst_wait: got %h expected %h", obs(2), exp);
    end
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      nvec++;
      if (obs(d) !== 35'd0) begin
        nerr++;
        $display("FAIL rst_async[%0d]: got %h expected 0", d, obs(d));
      end
      exp_dout[d] = 32'd0;
    end
    cmd_s[2] = c_CMD_IDLE;
    @(negedge clk);
    rst_n = 1'b1;
    access(2, c_CMD_READ, 32'h1F, 32'h0, 0, "rst_discard");
    // A read held straight across the reset pulse.
    cmd_s[2] = c_CMD_READ; addr_s[2] = 32'h3;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_dout[2] = 32'd0;
    access(2, c_CMD_READ, 32'h3, 32'h0, 0, "rst_reserve");
  endtask

  task automatic test_back_to_back();
    logic [34:0] exp;
    logic [31:0] first;
    cmd_s[0] = c_CMD_READ; addr_s[0] = 32'h1;
    @(negedge clk);
    first = mdl[0][1];
    nvec++;
    exp = {3'b100, first};
    if (obs(0) !== exp) begin
      nerr++;
      $display("FAIL b2b_first: got %h expected %h", obs(0), exp);
    end
    addr_s[0] = 32'h2;
    @(negedge clk);
    nvec++;
    exp = {3'b000, first};
    if (obs(0) !== exp) begin
      nerr++;
      $display("FAIL b2b_bubble: got %h expected %h", obs(0), exp);
    end
    exp_dout[0] = first;
    access(0, c_CMD_READ, 32'h2, 32'h0, 0, "b2b_second");
  endtask

  task automatic test_random();
    int d;
    logic [1:0] cmd;
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      d = $urandom_range(0, 2);
      cmd = ($urandom_range(0, 1) == 0) ? c_CMD_READ : c_CMD_WRITE;
      if ($urandom_range(0, 7) == 0) a = (32'h100 << $urandom_range(0, 23)) | 32'($urandom_range(0, 31));
      else a = 32'($urandom_range(0, 31));
      access(d, cmd, a, $urandom, $urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_read_latency();
    test_fault();
    test_abort();
    test_reset_midwait();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
